// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Central stall/flush controller for the 5-stage RV32I pipeline.
//               Produces the load enables for the PC and the IF/ID, ID/EX,
//               EX/MEM and MEM/WB registers, the bubble (flush) controls for
//               IF/ID and ID/EX, and the wrong-path I-fetch discard strobe.
//               Sources handled: D-cache stall, EX redirect, I-cache stall,
//               load-use hazard. A redirect that lands while an I-fetch is
//               outstanding moves the controller into DRAIN until the stale
//               response returns, and that response is dropped.
// Optional    : `define HAZARD_PERF_CNT_EN builds three saturating perf
//               counters (stall cycles, bubbles, redirects). Without it the
//               counter outputs are tied to zero and i_perf_clr is ignored.
// Ports       :
//   clk                  clock
//   rst_n                asynchronous active-low reset
//   i_imem_stall         I-fetch outstanding, no response this cycle
//   i_imem_resp          I-cache response valid this cycle
//   i_dmem_stall         D-access outstanding, no response this cycle
//   i_id_rs1/i_id_rs2    source register indices of the instruction in ID
//   i_id_rs1_used/_rs2_used  ID instruction actually reads rs1/rs2
//   i_ex_rd              destination register of the instruction in EX
//   i_ex_mem_read        EX instruction is a load
//   i_ex_redirect        EX resolved a mispredict; redirect PC is valid
//   i_perf_clr           synchronous clear of the perf counters
//   o_load_*             register load enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   o_flush_if_id/_id_ex load the all-zero control word instead of the input
//   o_discard_imem_resp  IF must drop the I-cache response this cycle
//   o_stall_cycles, o_bubble_count, o_redirect_count  perf counters
// Revision    : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_imem_stall,
  input  logic                  i_imem_resp,
  input  logic                  i_dmem_stall,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_redirect,
  input  logic                  i_perf_clr,
  output logic                  o_load_pc,
  output logic                  o_load_if_id,
  output logic                  o_load_id_ex,
  output logic                  o_load_ex_mem,
  output logic                  o_load_mem_wb,
  output logic                  o_flush_if_id,
  output logic                  o_flush_id_ex,
  output logic                  o_discard_imem_resp,
  output logic [PERF_CNT_W-1:0] o_stall_cycles,
  output logic [PERF_CNT_W-1:0] o_bubble_count,
  output logic [PERF_CNT_W-1:0] o_redirect_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_load_use;
  logic w_rs1_hit;
  logic w_rs2_hit;

  logic w_load_pc;
  logic w_load_if_id;
  logic w_load_id_ex;
  logic w_load_ex_mem;
  logic w_load_mem_wb;
  logic w_flush_if_id;
  logic w_flush_id_ex;
  logic w_discard;

  // Per-cycle event strobes for the perf counters.
  logic w_evt_stall;
  logic w_evt_bubble;
  logic w_evt_redirect;

  // --------------------------------------------------------------------------
  // Load-use detection. x0 is hardwired to zero, so a load targeting x0 never
  // creates a dependency.
  // --------------------------------------------------------------------------
  assign w_rs1_hit  = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
  assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_load_pc      = 1'b0;
    w_load_if_id   = 1'b0;
    w_load_id_ex   = 1'b0;
    w_load_ex_mem  = 1'b0;
    w_load_mem_wb  = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_discard      = 1'b0;
    w_evt_stall    = 1'b0;
    w_evt_bubble   = 1'b0;
    w_evt_redirect = 1'b0;

    case (r_state)
      ST_RUN: begin
        w_evt_stall = i_dmem_stall || i_imem_stall;
        if (i_dmem_stall) begin
          // Full freeze. A redirect sitting in EX is held there and is acted
          // on once the D-side stall clears.
        end else if (i_ex_redirect) begin
          w_load_pc      = 1'b1;
          w_load_if_id   = 1'b1;
          w_load_id_ex   = 1'b1;
          w_load_ex_mem  = 1'b1;
          w_load_mem_wb  = 1'b1;
          w_flush_if_id  = 1'b1;
          w_flush_id_ex  = 1'b1;
          w_evt_redirect = 1'b1;
          // A fetch still in flight belongs to the wrong path; its response
          // has to be swallowed before fetching restarts. A response that
          // arrives this very cycle is already killed by the IF/ID flush.
          if (i_imem_stall) begin
            w_state_nxt = ST_DRAIN;
          end
        end else if (i_imem_stall) begin
          // Full freeze while the fetch is outstanding.
        end else if (w_load_use) begin
          // Hold PC and IF/ID, insert one bubble into ID/EX, let the load
          // proceed so its data is forwardable next cycle.
          w_load_id_ex  = 1'b1;
          w_flush_id_ex = 1'b1;
          w_load_ex_mem = 1'b1;
          w_load_mem_wb = 1'b1;
          w_evt_bubble  = 1'b1;
        end else begin
          w_load_pc     = 1'b1;
          w_load_if_id  = 1'b1;
          w_load_id_ex  = 1'b1;
          w_load_ex_mem = 1'b1;
          w_load_mem_wb = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Front end stays parked; the back end keeps draining older
        // instructions and fills ID/EX with bubbles unless the D-side stalls.
        w_evt_stall   = 1'b1;
        w_discard     = 1'b1;
        w_load_id_ex  = !i_dmem_stall;
        w_load_ex_mem = !i_dmem_stall;
        w_load_mem_wb = !i_dmem_stall;
        w_flush_id_ex = !i_dmem_stall;
        if (i_imem_resp) begin
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, independent of the
  // clock, so no enable or discard can leak out during an asynchronous reset.
  assign o_load_pc           = rst_n && w_load_pc;
  assign o_load_if_id        = rst_n && w_load_if_id;
  assign o_load_id_ex        = rst_n && w_load_id_ex;
  assign o_load_ex_mem       = rst_n && w_load_ex_mem;
  assign o_load_mem_wb       = rst_n && w_load_mem_wb;
  assign o_flush_if_id       = rst_n && w_flush_if_id;
  assign o_flush_id_ex       = rst_n && w_flush_id_ex;
  assign o_discard_imem_resp = rst_n && w_discard;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_stall_cycles;
  logic [PERF_CNT_W-1:0] r_bubble_count;
  logic [PERF_CNT_W-1:0] r_redirect_count;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] val);
    if (&val) begin
      sat_inc = val;
    end else begin
      sat_inc = val + PERF_CNT_W'(1);
    end
  endfunction

  // Clear takes precedence over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles   <= '0;
      r_bubble_count   <= '0;
      r_redirect_count <= '0;
    end else if (i_perf_clr) begin
      r_stall_cycles   <= '0;
      r_bubble_count   <= '0;
      r_redirect_count <= '0;
    end else begin
      if (w_evt_stall) begin
        r_stall_cycles <= sat_inc(r_stall_cycles);
      end
      if (w_evt_bubble) begin
        r_bubble_count <= sat_inc(r_bubble_count);
      end
      if (w_evt_redirect) begin
        r_redirect_count <= sat_inc(r_redirect_count);
      end
    end
  end

  assign o_stall_cycles   = r_stall_cycles;
  assign o_bubble_count   = r_bubble_count;
  assign o_redirect_count = r_redirect_count;
`else
  logic w_unused_perf;
  assign w_unused_perf    = i_perf_clr ^ w_evt_stall ^ w_evt_bubble ^ w_evt_redirect;
  assign o_stall_cycles   = '0;
  assign o_bubble_count   = '0;
  assign o_redirect_count = '0;
`endif

  // --------------------------------------------------------------------------
  // EX only holds bubbles while draining, so a redirect cannot be raised here.
  // --------------------------------------------------------------------------
  a_no_redirect_in_drain : assert property (
    @(posedge clk) disable iff (!rst_n) (r_state == ST_DRAIN) |-> !i_ex_redirect
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed self-checking bench for hazard_stall_ctrl. Expected
//               control vectors are queued when a step is driven and popped
//               and compared on the following falling edge. Perf counter
//               expectations follow HAZARD_PERF_CNT_EN (zero when undefined).
//               Vector bit order: load_pc, load_if_id, load_id_ex,
//               load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, discard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_CNT_W = 32;

  localparam logic [7:0] C_RUN    = 8'hF8; // all loads, no flush
  localparam logic [7:0] C_FRZ    = 8'h00; // full freeze
  localparam logic [7:0] C_REDIR  = 8'hFE; // all loads, both flushes
  localparam logic [7:0] C_BUBBLE = 8'h3A; // hold PC/IF_ID, bubble ID/EX
  localparam logic [7:0] C_DRN_GO = 8'h3B; // drain, back end moving
  localparam logic [7:0] C_DRN_FZ = 8'h01; // drain, back end frozen

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  imem_stall, imem_resp, dmem_stall;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic                  id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect;
  logic                  perf_clr;
  logic                  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic                  flush_if_id, flush_id_ex, discard;
  logic [PERF_CNT_W-1:0] stall_cycles, bubble_count, redirect_count;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .REG_ADDR_W(REG_ADDR_W),
    .PERF_CNT_W(PERF_CNT_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_imem_stall        (imem_stall),
    .i_imem_resp         (imem_resp),
    .i_dmem_stall        (dmem_stall),
    .i_id_rs1            (id_rs1),
    .i_id_rs2            (id_rs2),
    .i_id_rs1_used       (id_rs1_used),
    .i_id_rs2_used       (id_rs2_used),
    .i_ex_rd             (ex_rd),
    .i_ex_mem_read       (ex_mem_read),
    .i_ex_redirect       (ex_redirect),
    .i_perf_clr          (perf_clr),
    .o_load_pc           (load_pc),
    .o_load_if_id        (load_if_id),
    .o_load_id_ex        (load_id_ex),
    .o_load_ex_mem       (load_ex_mem),
    .o_load_mem_wb       (load_mem_wb),
    .o_flush_if_id       (flush_if_id),
    .o_flush_id_ex       (flush_id_ex),
    .o_discard_imem_resp (discard),
    .o_stall_cycles      (stall_cycles),
    .o_bubble_count      (bubble_count),
    .o_redirect_count    (redirect_count)
  );

  function automatic logic [7:0] obs_vec();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
            flush_if_id, flush_id_ex, discard};
  endfunction

  function automatic logic [PERF_CNT_W-1:0] ecnt(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return PERF_CNT_W'(n);
`else
    return PERF_CNT_W'(n * 0);
`endif
  endfunction

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int s, input int b, input int r);
    n_vec++;
    assert (stall_cycles === ecnt(s)) else begin
      n_fail++;
      $error("FAIL %s stall_cycles: observed %0d expected %0d", tag, stall_cycles, ecnt(s));
    end
    n_vec++;
    assert (bubble_count === ecnt(b)) else begin
      n_fail++;
      $error("FAIL %s bubble_count: observed %0d expected %0d", tag, bubble_count, ecnt(b));
    end
    n_vec++;
    assert (redirect_count === ecnt(r)) else begin
      n_fail++;
      $error("FAIL %s redirect_count: observed %0d expected %0d", tag, redirect_count, ecnt(r));
    end
  endtask

  // One pipeline cycle: drive, queue expectation, compare on falling edge,
  // then advance past the rising edge.
  task automatic step(input string tag, input logic dst, input logic ist, input logic irsp,
                      input logic redir, input logic mrd, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                      input logic u2, input logic [7:0] exp);
    exp_t e;
    exp_t got;
    dmem_stall  = dst;
    imem_stall  = ist;
    imem_resp   = irsp;
    ex_redirect = redir;
    ex_mem_read = mrd;
    ex_rd       = rd;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    e.v   = exp;
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    check_vec(got.tag, obs_vec(), got.v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    perf_clr = 1'b0;
    dmem_stall = 1'b0; imem_stall = 1'b0; imem_resp = 1'b0; ex_redirect = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd1; id_rs2 = 5'd2;
    id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    #3;
    check_vec("reset_outputs", obs_vec(), C_FRZ);
    check_cnt("reset_counters", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //    tag              dst  ist  rsp  red  mrd  rd     rs1    u1   rs2    u2
    step("idle",           0,   0,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_RUN);
    step("t1_load_use_rs1",0,   0,   0,   0,   1,   5'd5,  5'd5,  1,   5'd2,  1,  C_BUBBLE);
    step("t1_after",       0,   0,   0,   0,   0,   5'd0,  5'd5,  1,   5'd2,  1,  C_RUN);
    check_cnt("t1_counters", 0, 1, 0);
    step("load_use_rs2",   0,   0,   0,   0,   1,   5'd7,  5'd3,  1,   5'd7,  1,  C_BUBBLE);
    step("rs2_not_used",   0,   0,   0,   0,   1,   5'd7,  5'd3,  1,   5'd7,  0,  C_RUN);
    step("t2_rd_x0",       0,   0,   0,   0,   1,   5'd0,  5'd0,  1,   5'd0,  1,  C_RUN);
    perf_clr = 1'b1;
    step("clr_vs_bubble",  0,   0,   0,   0,   1,   5'd9,  5'd9,  1,   5'd2,  1,  C_BUBBLE);
    perf_clr = 1'b0;
    check_cnt("perf_clr_wins", 0, 0, 0);
    step("t3_redirect",    0,   0,   0,   1,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_REDIR);
    step("t3_after",       0,   0,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_RUN);
    step("redir_with_resp",0,   0,   1,   1,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_REDIR);
    step("redir_resp_run", 0,   0,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_RUN);
    check_cnt("t3_counters", 0, 0, 2);
    step("t4_redir_istall",0,   1,   0,   1,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_REDIR);
    step("t4_drain1",      0,   1,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_DRN_GO);
    step("t4_drain2_dst",  1,   1,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_DRN_FZ);
    step("t4_drain_resp",  0,   0,   1,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_DRN_GO);
    step("t4_back_to_run", 0,   0,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_RUN);
    check_cnt("t4_counters", 4, 0, 3);
    step("istall_freeze",  0,   1,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_FRZ);
    step("istall_over_lu", 0,   1,   0,   0,   1,   5'd4,  5'd4,  1,   5'd2,  1,  C_FRZ);
    for (int i = 0; i < 4; i++) begin
      step("t5_dstall_hold",1,  0,   0,   1,   1,   5'd6,  5'd6,  1,   5'd2,  1,  C_FRZ);
    end
    step("t5_redir_lu",    0,   0,   0,   1,   1,   5'd6,  5'd6,  1,   5'd2,  1,  C_REDIR);
    step("t5_after",       0,   0,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_RUN);
    check_cnt("t5_counters", 10, 0, 4);
    step("t6_redir_istall",0,   1,   0,   1,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_REDIR);
    step("t6_drain",       0,   1,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_DRN_GO);

    // Asynchronous reset between clock edges while in DRAIN.
    rst_n = 1'b0;
    #1;
    check_vec("t6_async_rst_out", obs_vec(), C_FRZ);
    check_cnt("t6_async_rst_cnt", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Still fetching: RUN freezes, whereas a surviving DRAIN would not.
    step("t6_run_after_rst",0,  1,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_FRZ);
    step("t6_idle",        0,   0,   0,   0,   0,   5'd0,  5'd1,  1,   5'd2,  1,  C_RUN);
    check_cnt("t6_counters", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
